prog_moore_fsm: RTL and testbench

Programmable Moore state machine: the next-state table and the per-state output table are loaded at run time through a configuration port, then the machine steps on qualified input samples. It generalises our fixed two-state, externally-driven FSM to 2^STATE_W states, IN_W-bit inputs and OUT_W-bit outputs. The block sits between a controller that programs the behaviour and the datapath that consumes `out`. It is also the reusable FSM-under-test harness for the state-machine exercises.

---
 rtl/prog_moore_fsm.sv | 156 +++++++++++++++
 tb/tb_prog_moore_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_moore_fsm.sv
// prog_moore_fsm: programmable Moore state machine.
// The next-state table (indexed {state, in}) and the per-state output table are
// written through a configuration port while run = 0. While run = 1, the machine
// takes one step for each cycle in which in_valid is high.
// Optional feature macro: PFSM_VALID_MASK_EN. When it is defined, each next-state
// entry has a valid bit. A step onto an entry that was never written sets a sticky
// trap flag instead of moving.
module prog_moore_fsm #(
    parameter int STATE_W     = 2,
    parameter int IN_W        = 1,
    parameter int OUT_W       = 4,
    parameter int RESET_STATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_i,
    input  logic               restart_i,
    input  logic               in_valid_i,
    input  logic [IN_W-1:0]    in_i,
    input  logic               cfg_we_i,
    input  logic               cfg_kind_i,
    input  logic [STATE_W-1:0] cfg_state_i,
    input  logic [IN_W-1:0]    cfg_in_i,
    input  logic [STATE_W-1:0] cfg_ns_i,
    input  logic [OUT_W-1:0]   cfg_out_i,
    output logic               cfg_ready_o,
    output logic               cfg_err_o,
    output logic [STATE_W-1:0] cur_state_o,
    output logic [OUT_W-1:0]   out_o,
    output logic [15:0]        step_cnt_o,
    output logic               trap_o
);

    localparam int IDX_W      = STATE_W + IN_W;
    localparam int NUM_STATES = 1 << STATE_W;
    localparam int NS_DEPTH   = 1 << IDX_W;
    localparam logic [STATE_W-1:0] RST_STATE = STATE_W'(RESET_STATE);

    logic [STATE_W-1:0] state_q;
    logic [15:0]        step_cnt_q;
    logic               cfg_err_q;

    // The tables are held in flops rather than RAM because reset must restore every entry.
    logic [NS_DEPTH*STATE_W-1:0]  ns_flat;
    logic [NUM_STATES*OUT_W-1:0]  out_flat;

    // A write is accepted only in configuration mode.
    logic             cfg_ok;
    logic [IDX_W-1:0] cfg_idx;
    logic [IDX_W-1:0] step_idx;
    logic [STATE_W-1:0] step_ns;
    logic             step_go;

    assign cfg_ok   = cfg_we_i & ~run_i;
    assign cfg_idx  = {cfg_state_i, cfg_in_i};
    assign step_idx = {state_q, in_i};
    assign step_go  = run_i & in_valid_i;
    assign step_ns  = ns_flat[int'(step_idx)*STATE_W +: STATE_W];

    genvar gi;
    generate
        for (gi = 0; gi < NS_DEPTH; gi++) begin : g_ns
            // On reset, each entry points back to its own state (gi >> IN_W).
            localparam logic [STATE_W-1:0] SELF_STATE = STATE_W'(gi >> IN_W);
            logic [STATE_W-1:0] entry_q;

            // Next-state entry: reset to a self-loop, then loaded by kind-0 writes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q <= SELF_STATE;
                end else if (cfg_ok && !cfg_kind_i && cfg_idx == IDX_W'(gi)) begin
                    entry_q <= cfg_ns_i;
                end
            end
            assign ns_flat[gi*STATE_W +: STATE_W] = entry_q;
        end

        for (gi = 0; gi < NUM_STATES; gi++) begin : g_out
            logic [OUT_W-1:0] entry_q;

            // Output entry: reset to zero, then loaded by kind-1 writes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q <= '0;
                end else if (cfg_ok && cfg_kind_i && cfg_state_i == STATE_W'(gi)) begin
                    entry_q <= cfg_out_i;
                end
            end
            assign out_flat[gi*OUT_W +: OUT_W] = entry_q;
        end
    endgenerate

`ifdef PFSM_VALID_MASK_EN
    logic [NS_DEPTH-1:0] valid_flat;
    logic                trap_q;
    logic                step_valid;

    generate
        for (gi = 0; gi < NS_DEPTH; gi++) begin : g_valid
            logic valid_q;

            // Valid bit: marks a next-state entry as programmed after a kind-0 write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else if (cfg_ok && !cfg_kind_i && cfg_idx == IDX_W'(gi)) begin
                    valid_q <= 1'b1;
                end
            end
            assign valid_flat[gi] = valid_q;
        end
    endgenerate

    assign step_valid = valid_flat[step_idx];
    assign trap_o     = trap_q;
`else
    assign trap_o = 1'b0;
`endif

    // Machine state, step counter and flags. Priority is reset, then restart, then step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_STATE;
            step_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
`ifdef PFSM_VALID_MASK_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            cfg_err_q <= cfg_we_i & run_i;
            if (restart_i) begin
                state_q    <= RST_STATE;
                step_cnt_q <= '0;
            end else if (step_go) begin
`ifdef PFSM_VALID_MASK_EN
                if (step_valid) begin
                    state_q    <= step_ns;
                    step_cnt_q <= step_cnt_q + 16'd1;
                end else begin
                    trap_q <= 1'b1;
                end
`else
                state_q    <= step_ns;
                step_cnt_q <= step_cnt_q + 16'd1;
`endif
            end
        end
    end

    assign cfg_ready_o = ~run_i;
    assign cfg_err_o   = cfg_err_q;
    assign cur_state_o = state_q;
    assign out_o       = out_flat[int'(state_q)*OUT_W +: OUT_W];
    assign step_cnt_o  = step_cnt_q;

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Directed testbench for prog_moore_fsm with default parameters (STATE_W=2, IN_W=1, OUT_W=4).
// The expected values depend on PFSM_VALID_MASK_EN, in the same way the design does.
module tb_prog_moore_fsm;

    logic        clk = 1'b0;
    logic        reset, run, restart, in_valid, in_sym;
    logic        cfg_we, cfg_kind, cfg_in;
    logic [1:0]  cfg_state, cfg_ns;
    logic [3:0]  cfg_out;
    logic        cfg_ready, cfg_err, trap;
    logic [1:0]  cur_state;
    logic [3:0]  out;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;

`ifdef PFSM_VALID_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    prog_moore_fsm #(.STATE_W(2), .IN_W(1), .OUT_W(4), .RESET_STATE(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run),
        .restart_i   (restart),
        .in_valid_i  (in_valid),
        .in_i        (in_sym),
        .cfg_we_i    (cfg_we),
        .cfg_kind_i  (cfg_kind),
        .cfg_state_i (cfg_state),
        .cfg_in_i    (cfg_in),
        .cfg_ns_i    (cfg_ns),
        .cfg_out_i   (cfg_out),
        .cfg_ready_o (cfg_ready),
        .cfg_err_o   (cfg_err),
        .cur_state_o (cur_state),
        .out_o       (out),
        .step_cnt_o  (step_cnt),
        .trap_o      (trap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ns(input logic [1:0] s, input logic i, input logic [1:0] n);
        cfg_we = 1'b1; cfg_kind = 1'b0; cfg_state = s; cfg_in = i; cfg_ns = n;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic write_out(input logic [1:0] s, input logic [3:0] o);
        cfg_we = 1'b1; cfg_kind = 1'b1; cfg_state = s; cfg_out = o;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 0; restart = 0; in_valid = 0; in_sym = 0;
        cfg_we = 0; cfg_kind = 0; cfg_state = 0; cfg_in = 0; cfg_ns = 0; cfg_out = 0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", cur_state); end
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", step_cnt); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        $display("reset: state=%0d out=%h cnt=%0d", cur_state, out, step_cnt);
    endtask

    task automatic test_unprogrammed();
        run = 1; in_valid = 1; in_sym = 1;
        repeat (3) tick();
        run = 0; in_valid = 0;
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL unprog_state got %0d want 0", cur_state); end
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL unprog_out got %h want 0", out); end
        checks++; if (step_cnt !== (MASK ? 16'd0 : 16'd3)) begin errors++; $display("FAIL unprog_cnt got %0d want %0d", step_cnt, MASK ? 0 : 3); end
        checks++; if (trap !== MASK) begin errors++; $display("FAIL unprog_trap got %b want %b", trap, MASK); end
        $display("unprogrammed: state=%0d cnt=%0d trap=%b", cur_state, step_cnt, trap);
    endtask

    task automatic test_toggle();
        logic [3:0] exp_out;
        write_ns(2'd0, 1'b1, 2'd1);
        write_ns(2'd1, 1'b1, 2'd0);
        write_out(2'd0, 4'h3);
        checks++; if (out !== 4'h3) begin errors++; $display("FAIL toggle_out_write got %h want 3", out); end
        write_out(2'd1, 4'hC);
        run = 1; in_valid = 1; in_sym = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_out = (k % 2 == 0) ? 4'hC : 4'h3;
            checks++; if (out !== exp_out) begin errors++; $display("FAIL toggle_step%0d got %h want %h", k, out, exp_out); end
            $display("toggle step %0d: state=%0d out=%h", k, cur_state, out);
        end
        run = 0; in_valid = 0;
    endtask

    task automatic test_reject();
        run = 1; in_valid = 0;
        cfg_we = 1; cfg_kind = 1; cfg_state = 2'd0; cfg_out = 4'hF;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reject_ready got %b want 0", cfg_ready); end
        tick();
        cfg_we = 0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_err_pulse got %b want 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reject_err_clear got %b want 0", cfg_err); end
        checks++; if (out !== 4'h3) begin errors++; $display("FAIL reject_table got %h want 3", out); end
        run = 0;
        $display("reject: cfg_err cleared, out=%h", out);
    endtask

    task automatic test_restart();
        logic [15:0] exp_cnt;
        run = 1; in_valid = 1; in_sym = 1;
        tick();
        checks++; if (cur_state !== 2'd1) begin errors++; $display("FAIL restart_pre_state got %0d want 1", cur_state); end
        restart = 1;
        tick();
        restart = 0; in_valid = 0;
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL restart_state got %0d want 0", cur_state); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt got %0d want 0", step_cnt); end
        checks++; if (out !== 4'h3) begin errors++; $display("FAIL restart_out got %h want 3", out); end
        $display("restart: state=%0d cnt=%0d out=%h", cur_state, step_cnt, out);
        in_valid = 1; reset = 1;
        tick();
        reset = 0; in_valid = 0;
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL midreset_out got %h want 0", out); end
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL midreset_state got %0d want 0", cur_state); end
        in_valid = 1;
        tick();
        in_valid = 0; run = 0;
        exp_cnt = MASK ? 16'd0 : 16'd1;
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL midreset_table_state got %0d want 0", cur_state); end
        checks++; if (step_cnt !== exp_cnt) begin errors++; $display("FAIL midreset_table_cnt got %0d want %0d", step_cnt, exp_cnt); end
        checks++; if (trap !== MASK) begin errors++; $display("FAIL midreset_trap got %b want %b", trap, MASK); end
        $display("mid-run reset: state=%0d out=%h cnt=%0d", cur_state, out, step_cnt);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_seq [3];
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd3; exp_seq[2] = 2'd0;
        do_reset();
        write_ns(2'd2, 1'b1, 2'd3);
        write_ns(2'd3, 1'b1, 2'd0);
        // The last write and the rise of run happen on the same edge.
        cfg_we = 1; cfg_kind = 0; cfg_state = 2'd0; cfg_in = 1'b1; cfg_ns = 2'd2;
        tick();
        cfg_we = 0; run = 1; in_valid = 1; in_sym = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (cur_state !== exp_seq[k]) begin errors++; $display("FAIL b2b_step%0d got %0d want %0d", k, cur_state, exp_seq[k]); end
            $display("back-to-back step %0d: state=%0d", k, cur_state);
        end
        run = 0; in_valid = 0;
        checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d want 3", step_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        write_ns(2'd0, 1'b0, 2'd0);
        run = 1; in_valid = 1; in_sym = 0;
        repeat (65535) tick();
        checks++; if (step_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h want ffff", step_cnt); end
        tick();
        checks++; if (step_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", step_cnt); end
        tick();
        run = 0; in_valid = 0;
        checks++; if (step_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_one got %h want 0001", step_cnt); end
        $display("wrap: after 65537 steps cnt=%0d", step_cnt);
    endtask

    task automatic test_valid_mask();
        logic [15:0] exp_cnt;
        do_reset();
        write_ns(2'd0, 1'b0, 2'd1);
        run = 1; in_valid = 1; in_sym = 1;
        tick();
        run = 0; in_valid = 0;
        exp_cnt = MASK ? 16'd0 : 16'd1;
        checks++; if (cur_state !== 2'd0) begin errors++; $display("FAIL mask_state got %0d want 0", cur_state); end
        checks++; if (step_cnt !== exp_cnt) begin errors++; $display("FAIL mask_cnt got %0d want %0d", step_cnt, exp_cnt); end
        checks++; if (trap !== MASK) begin errors++; $display("FAIL mask_trap got %b want %b", trap, MASK); end
        $display("valid mask: state=%0d cnt=%0d trap=%b", cur_state, step_cnt, trap);
    endtask

    initial begin
        test_reset();
        test_unprogrammed();
        test_toggle();
        test_reject();
        test_restart();
        test_back_to_back();
        test_wrap();
        test_valid_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
